// File: rtl/reg_wb_ctrl.sv
// Register-file write-back arbiter: post-reset clear sweep, ALU priority,
// 2-entry load FIFO with ALU squash. Optional read bypass: REG_WB_BYPASS_EN.
module reg_wb_ctrl #(
  parameter int pw = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_valid,
  input  logic [pw-1:0] alu_addr,
  input  logic [7:0]    alu_data,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [pw-1:0] mem_addr,
  input  logic [7:0]    mem_data,
  output logic          wr_en,
  output logic [pw-1:0] wr_addr,
  output logic [7:0]    wr_dat,
  output logic          clr_busy,
  output logic [1:0]    fifo_cnt
`ifdef REG_WB_BYPASS_EN
  ,
  input  logic [pw-1:0] rd_addrA,
  input  logic [pw-1:0] rd_addrB,
  input  logic [7:0]    rf_datA,
  input  logic [7:0]    rf_datB,
  output logic [7:0]    byp_datA,
  output logic [7:0]    byp_datB
`endif
);

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t        state;
  logic [pw-1:0] cnt;

  logic          v0, v1;
  logic [pw-1:0] a0, a1;
  logic [7:0]    d0, d1;

  logic          k0, k1;
  logic          nv0, nv1;
  logic [pw-1:0] na0, na1;
  logic [7:0]    nd0, nd1;
  logic          push_ok;

  assign clr_busy  = (state == CLEAR);
  assign mem_ready = (state == RUN) && !(v0 && v1);
  assign fifo_cnt  = {v0 & v1, v0 ^ v1};

  // Entry 0 is always the head; a valid entry 1 implies a valid entry 0.
  // Survivors of squash/pop are compacted toward entry 0, then the push lands.
  always_comb begin
    k0 = v0 && !(alu_valid ? (a0 == alu_addr) : 1'b1);
    k1 = v1 && !(alu_valid && (a1 == alu_addr));
    push_ok = mem_valid && mem_ready
              && !(alu_valid && (mem_addr == alu_addr));
    nv0 = k0 | k1;
    na0 = k0 ? a0 : a1;
    nd0 = k0 ? d0 : d1;
    nv1 = k0 & k1;
    na1 = a1;
    nd1 = d1;
    if (push_ok) begin
      if (!nv0) begin
        nv0 = 1'b1;
        na0 = mem_addr;
        nd0 = mem_data;
      end else begin
        nv1 = 1'b1;
        na1 = mem_addr;
        nd1 = mem_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= CLEAR;
      cnt     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_dat  <= 8'h00;
      v0      <= 1'b0;
      v1      <= 1'b0;
      a0      <= '0;
      a1      <= '0;
      d0      <= 8'h00;
      d1      <= 8'h00;
    end else begin
      unique case (state)
        CLEAR: begin
          wr_en   <= 1'b1;
          wr_addr <= cnt;
          wr_dat  <= 8'h00;
          cnt     <= cnt + pw'(1);
          if (cnt == {pw{1'b1}}) state <= RUN;
        end
        RUN: begin
          v0 <= nv0;
          v1 <= nv1;
          a0 <= na0;
          a1 <= na1;
          d0 <= nd0;
          d1 <= nd1;
          if (alu_valid) begin
            wr_en   <= 1'b1;
            wr_addr <= alu_addr;
            wr_dat  <= alu_data;
          end else if (v0) begin
            wr_en   <= 1'b1;
            wr_addr <= a0;
            wr_dat  <= d0;
          end else begin
            wr_en   <= 1'b0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

`ifdef REG_WB_BYPASS_EN
  assign byp_datA = (wr_en && wr_addr == rd_addrA) ? wr_dat : rf_datA;
  assign byp_datB = (wr_en && wr_addr == rd_addrB) ? wr_dat : rf_datB;
`endif

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Scoreboard bench for reg_wb_ctrl (pw=2): every write-port pulse is
// popped from an expected-write queue; tasks add cycle-exact checks.
module tb_reg_wb_ctrl;

  localparam int PW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_valid;
  logic [PW-1:0] alu_addr;
  logic [7:0]    alu_data;
  logic          mem_valid;
  logic          mem_ready;
  logic [PW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic          wr_en;
  logic [PW-1:0] wr_addr;
  logic [7:0]    wr_dat;
  logic          clr_busy;
  logic [1:0]    fifo_cnt;
`ifdef REG_WB_BYPASS_EN
  logic [PW-1:0] rd_addrA, rd_addrB;
  logic [7:0]    rf_datA, rf_datB;
  logic [7:0]    byp_datA, byp_datB;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [PW+7:0] exp_q[$];

  always #5 clk = ~clk;

  reg_wb_ctrl #(.pw(PW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_dat    (wr_dat),
    .clr_busy  (clr_busy),
    .fifo_cnt  (fifo_cnt)
`ifdef REG_WB_BYPASS_EN
    ,
    .rd_addrA  (rd_addrA),
    .rd_addrB  (rd_addrB),
    .rf_datA   (rf_datA),
    .rf_datB   (rf_datB),
    .byp_datA  (byp_datA),
    .byp_datB  (byp_datB)
`endif
  );

  // Write-port monitor: each write must match the oldest expected one.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got addr=%0d dat=%02h, none expected",
                 wr_addr, wr_dat);
      end else begin
        logic [PW+7:0] e;
        e = exp_q.pop_front();
        if ({wr_addr, wr_dat} !== e) begin
          miscompares++;
          $display("FAIL write_order: got addr=%0d dat=%02h, want addr=%0d dat=%02h",
                   wr_addr, wr_dat, e[PW+7:8], e[7:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got,
                     input logic [7:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic expect_wr(input logic [PW-1:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    alu_addr  = '0;
    alu_data  = 8'h00;
    mem_addr  = '0;
    mem_data  = 8'h00;
  endtask

  task automatic check_sweep();
    for (int i = 0; i < (1 << PW); i++) expect_wr(PW'(i), 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < (1 << PW); i++) begin
      @(negedge clk);
      chk("sweep_wr_en", {7'd0, wr_en}, 8'd1);
      chk("sweep_addr", {6'd0, wr_addr}, 8'(i));
      chk("sweep_dat", wr_dat, 8'h00);
      if (i < (1 << PW) - 1) chk("sweep_busy", {7'd0, clr_busy}, 8'd1);
    end
    @(negedge clk);
    chk("run_busy", {7'd0, clr_busy}, 8'd0);
    chk("run_ready", {7'd0, mem_ready}, 8'd1);
    chk("run_wr_en", {7'd0, wr_en}, 8'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    chk("rst_wr_en", {7'd0, wr_en}, 8'd0);
    chk("rst_wr_addr", {6'd0, wr_addr}, 8'd0);
    chk("rst_wr_dat", wr_dat, 8'h00);
    chk("rst_busy", {7'd0, clr_busy}, 8'd1);
    chk("rst_ready", {7'd0, mem_ready}, 8'd0);
    chk("rst_cnt", {6'd0, fifo_cnt}, 8'd0);
    check_sweep();
  endtask

  task automatic test_fifo_order();
    mem_valid = 1'b1; mem_addr = 2'd1; mem_data = 8'h11;
    expect_wr(2'd1, 8'h11);
    expect_wr(2'd2, 8'h22);
    @(negedge clk);
    chk("fo_cnt1", {6'd0, fifo_cnt}, 8'd1);
    chk("fo_no_passthru", {7'd0, wr_en}, 8'd0);
    mem_addr = 2'd2; mem_data = 8'h22;
    @(negedge clk);
    chk("fo_pushpop_cnt", {6'd0, fifo_cnt}, 8'd1);
    chk("fo_first_addr", {6'd0, wr_addr}, 8'd1);
    mem_valid = 1'b0;
    @(negedge clk);
    chk("fo_second_dat", wr_dat, 8'h22);
    chk("fo_cnt0", {6'd0, fifo_cnt}, 8'd0);
    @(negedge clk);
    chk("fo_idle", {7'd0, wr_en}, 8'd0);
  endtask

  task automatic test_squash();
    mem_valid = 1'b1; mem_addr = 2'd3; mem_data = 8'hAA;
    @(negedge clk);
    chk("sq_cnt1", {6'd0, fifo_cnt}, 8'd1);
    mem_valid = 1'b0;
    alu_valid = 1'b1; alu_addr = 2'd3; alu_data = 8'h55;
    expect_wr(2'd3, 8'h55);
    @(negedge clk);
    chk("sq_alu_dat", wr_dat, 8'h55);
    chk("sq_cnt0", {6'd0, fifo_cnt}, 8'd0);
    alu_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("sq_no_load", {7'd0, wr_en}, 8'd0);
  endtask

  task automatic test_same_cycle_squash();
    mem_valid = 1'b1; mem_addr = 2'd0; mem_data = 8'h33;
    alu_valid = 1'b1; alu_addr = 2'd0; alu_data = 8'h44;
    expect_wr(2'd0, 8'h44);
    @(negedge clk);
    idle_inputs();
    chk("scs_cnt0", {6'd0, fifo_cnt}, 8'd0);
    repeat (2) @(negedge clk);
    chk("scs_no_load", {7'd0, wr_en}, 8'd0);
  endtask

  task automatic test_alu_priority();
    mem_valid = 1'b1; mem_addr = 2'd1; mem_data = 8'h10;
    @(negedge clk);
    mem_valid = 1'b0;
    alu_valid = 1'b1; alu_addr = 2'd2; alu_data = 8'h20;
    for (int i = 0; i < 3; i++) expect_wr(2'd2, 8'h20);
    expect_wr(2'd1, 8'h10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ap_alu_addr", {6'd0, wr_addr}, 8'd2);
      chk("ap_held", {6'd0, fifo_cnt}, 8'd1);
    end
    alu_valid = 1'b0;
    @(negedge clk);
    chk("ap_load_addr", {6'd0, wr_addr}, 8'd1);
    chk("ap_load_dat", wr_dat, 8'h10);
    chk("ap_cnt0", {6'd0, fifo_cnt}, 8'd0);
    @(negedge clk);
  endtask

`ifdef REG_WB_BYPASS_EN
  task automatic test_bypass();
    alu_valid = 1'b1; alu_addr = 2'd2; alu_data = 8'h7E;
    expect_wr(2'd2, 8'h7E);
    @(negedge clk);
    alu_valid = 1'b0;
    rd_addrA = 2'd2; rd_addrB = 2'd1;
    rf_datA = 8'h99; rf_datB = 8'hC3;
    #1;
    chk("byp_A", byp_datA, 8'h7E);
    chk("byp_B", byp_datB, 8'hC3);
    @(negedge clk);
    #1;
    chk("byp_A_idle", byp_datA, 8'h99);
  endtask
`endif

  task automatic test_reset_flush();
    alu_valid = 1'b1; alu_addr = 2'd3; alu_data = 8'h01;
    mem_valid = 1'b1; mem_addr = 2'd1; mem_data = 8'hB1;
    expect_wr(2'd3, 8'h01);
    expect_wr(2'd3, 8'h02);
    @(negedge clk);
    chk("rf_cnt1", {6'd0, fifo_cnt}, 8'd1);
    alu_data = 8'h02;
    mem_addr = 2'd2; mem_data = 8'hB2;
    @(negedge clk);
    chk("rf_cnt2", {6'd0, fifo_cnt}, 8'd2);
    chk("rf_ready0", {7'd0, mem_ready}, 8'd0);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rf_flushed", {6'd0, fifo_cnt}, 8'd0);
    chk("rf_busy", {7'd0, clr_busy}, 8'd1);
    chk("rf_wr_en", {7'd0, wr_en}, 8'd0);
    check_sweep();
    repeat (4) @(negedge clk);
    chk("rf_no_load", {7'd0, wr_en}, 8'd0);
  endtask

  initial begin
`ifdef REG_WB_BYPASS_EN
    rd_addrA = '0; rd_addrB = '0; rf_datA = 8'h00; rf_datB = 8'h00;
`endif
    test_reset();
    test_fifo_order();
    test_squash();
    test_same_cycle_squash();
    test_alu_priority();
`ifdef REG_WB_BYPASS_EN
    test_bypass();
`endif
    test_reset_flush();
    chk("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
